// File: rtl/esp32_prog_sequencer.sv
// rtl/esp32_prog_sequencer.sv - DTR/RTS auto-program sequencer for ESP32 EN/IO0 reset and bootloader entry
module esp32_prog_sequencer #(
    parameter int T_EN_LOW   = 2500000,
    parameter int T_IO0_HOLD = 1250000,
    parameter int T_SETTLE   = 250000,
    parameter int CNT_W      = 32
) (
    input  logic clk_25mhz,
    input  logic rst,
    input  logic i_start,
    input  logic i_boot,
    output logic o_ndtr,
    output logic o_nrts,
    output logic o_busy,
    output logic o_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EN_LOW = 2'd1,
        BOOT   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] EN_LAST     = CNT_W'(T_EN_LOW - 1);
    localparam logic [CNT_W-1:0] IO0_LAST    = CNT_W'(T_IO0_HOLD - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_SETTLE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             mode;
    logic             mode_nxt;
    logic             ndtr_nxt;
    logic             nrts_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode   <= 1'b0;
            o_ndtr <= 1'b1;
            o_nrts <= 1'b1;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mode   <= mode_nxt;
            o_ndtr <= ndtr_nxt;
            o_nrts <= nrts_nxt;
            o_busy <= busy_nxt;
            o_done <= done_nxt;
        end
    end

    // Next state; each phase ends on the cycle its counter reaches its last value.
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = EN_LOW;
                    mode_nxt  = i_boot;
                end
            end
            EN_LOW: begin
                if (cnt == EN_LAST) begin
                    state_nxt = mode ? BOOT : SETTLE;
                end
            end
            BOOT: begin
                if (cnt == IO0_LAST) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counter restarts at zero on every phase entry and rests at zero while idle.
    always_comb begin
        cnt_nxt = '0;
        if (state_nxt == state && state != IDLE) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Line levels are decoded from the next state so they change on the same edge
    // as the state; EN_LOW->BOOT flips both bits together and 00 is never produced.
    always_comb begin
        ndtr_nxt = 1'b1;
        nrts_nxt = 1'b1;
        busy_nxt = 1'b1;
        case (state_nxt)
            IDLE: begin
                busy_nxt = 1'b0;
            end
            EN_LOW: begin
                nrts_nxt = 1'b0;
            end
            BOOT: begin
                ndtr_nxt = 1'b0;
            end
            SETTLE: begin
                ndtr_nxt = 1'b1;
                nrts_nxt = 1'b1;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/esp32_prog_sequencer.md
# esp32_prog_sequencer

Drives the ESP32 auto-program handshake from the FPGA side. Generates the active-low DTR/RTS pair (`o_ndtr`, `o_nrts`) that a USB-serial bridge would normally produce, so the existing DTR/RTS→EN/IO0 decoder can reset the ESP32 into normal run or into its ROM bootloader without a host. The sequencer sits in front of that decoder's input pair and is selected by a board-level mux, which is outside this block.

## Interface
Parameters:
- `T_EN_LOW`, default 2500000: cycles EN is held low (100 ms at 25 MHz); must be ≥1.
- `T_IO0_HOLD`, default 1250000: cycles IO0 is held low after EN is released (50 ms); must be ≥1.
- `T_SETTLE`, default 250000: cycles of idle levels after release before a new request is accepted (10 ms); must be ≥1.
- `CNT_W`, default 32: width of the phase counter; must satisfy 2^CNT_W > max(T_EN_LOW, T_IO0_HOLD, T_SETTLE).

Ports:
- `clk_25mhz`, in, 1: the only clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `i_start`, in, 1: request strobe; sampled only while idle.
- `i_boot`, in, 1: mode, sampled together with `i_start`. 1 = bootloader entry, 0 = plain reset into run.
- `o_ndtr`, out, 1: DTR level (active-low, bridge convention); registered.
- `o_nrts`, out, 1: RTS level (active-low); registered.
- `o_busy`, out, 1: a sequence is in progress; registered.
- `o_done`, out, 1: one-cycle pulse when the sequence completes; registered.

## Operation
- Decoder mapping, with {ndtr, nrts} → {EN, IO0}:
  - 11 → 11
  - 00 → 11
  - 10 → 01 (EN low)
  - 01 → 10 (IO0 low)
- The block only ever emits 11, 10 and 01. It never emits 00.
- States and their {o_ndtr, o_nrts} outputs:
  - IDLE = 11
  - EN_LOW = 10
  - BOOT = 01
  - SETTLE = 11
- Transitions:
  - IDLE → EN_LOW when `i_start`=1. `i_boot` is latched into an internal mode bit at that edge.
  - EN_LOW → BOOT after T_EN_LOW cycles if mode=1. EN_LOW → SETTLE after T_EN_LOW cycles if mode=0.
  - BOOT → SETTLE after T_IO0_HOLD cycles.
  - SETTLE → IDLE after T_SETTLE cycles.
- Counter:
  - Loaded with 0 on every state entry and incremented each cycle.
  - The state exits on the cycle the counter equals T_x−1.
  - The counter never wraps.
- EN_LOW→BOOT is a direct 10→01 change. Both bits switch on the same edge, with no intermediate 11 or 00.
- `i_start` and `i_boot` are ignored outside IDLE. Changing `i_boot` mid-sequence has no effect.
- `o_busy` is 1 in EN_LOW, BOOT and SETTLE, and 0 in IDLE.
- `o_done` is 1 for exactly the first IDLE cycle following SETTLE, and never otherwise.
- Reset:
  - Values after a reset edge: state IDLE, {o_ndtr, o_nrts}=11, `o_busy`=0, `o_done`=0, counter 0, mode 0.
  - Reset mid-sequence aborts immediately. The ESP32 lines are released via 11 on the next edge, and no `o_done` is produced.
  - Reset has priority over `i_start` in the same cycle.

## Timing
- Latency: `i_start` sampled at edge k → outputs 10 and `o_busy`=1 visible after edge k.
- EN_LOW output lasts exactly T_EN_LOW cycles, BOOT exactly T_IO0_HOLD, and SETTLE exactly T_SETTLE.
- Total sequence from the edge accepting `i_start` to the `o_done` cycle:
  - Bootloader mode: T_EN_LOW+T_IO0_HOLD+T_SETTLE cycles.
  - Run mode: T_EN_LOW+T_SETTLE cycles.
- `i_start` held high continuously:
  - A new sequence starts on the `o_done` cycle's edge, since that cycle is IDLE.
  - `o_done` and the new sequence's `o_busy` are therefore adjacent, with no gap cycle.
- All outputs are flop outputs, so there are no combinational paths from inputs to outputs.

## Test plan
Parameters for the bench: T_EN_LOW=4, T_IO0_HOLD=3, T_SETTLE=2.

1. Bootloader sequence:
   - Stimulus: pulse `i_start`=1 with `i_boot`=1 for one cycle.
   - Required: {ndtr, nrts} = 10 for 4 cycles, then 01 for 3 cycles, then 11.
   - `o_busy` high for 9 cycles, then `o_done` high for 1 cycle with `o_busy`=0.
2. Run reset:
   - Stimulus: `i_start` with `i_boot`=0.
   - Required: 10 for 4 cycles, then 11.
   - BOOT never entered; `o_done` 6 cycles after acceptance.
3. Ignored inputs:
   - Stimulus: pulse `i_start` during BOOT, and toggle `i_boot` during EN_LOW.
   - Required: the waveform is identical to scenario 1, with a single `o_done`.
4. Reset mid-BOOT:
   - Stimulus: assert `rst` on the 2nd BOOT cycle.
   - Required: 11, `o_busy`=0 and `o_done`=0 after that edge, and no later `o_done`.
   - A fresh `i_start` then produces a full scenario-1 sequence.
5. Back-to-back requests:
   - Stimulus: hold `i_start`=1 with `i_boot`=1 for 25 cycles.
   - Required: two complete sequences, each followed by a single `o_done`.
   - The second EN_LOW begins on the edge after the first `o_done` cycle.
   - 00 is never observed on {ndtr, nrts}.
6. Decoder loopback:
   - Stimulus: feed the outputs into a reference DTR/RTS→EN/IO0 model.
   - Required: EN=0/IO0=1 for 4 cycles, then EN=1/IO0=0 for 3 cycles, then 11.
